mul_round_sequencer: RTL and testbench
======================================

// Module: mul_round_sequencer
// PURPOSE
//  Front-end sequencer that drives the ADDER tree input interface: MUL_results, MUL_DATA_valid, wsize, wround, stride.
//  Fetches one multiplier-array result beat per window position from upstream via valid/ready.
//  Replays each beat for the wround count its kernel size requires: 3x3=1, 5x5=2, 7x7=4.
//  Counts returned Psum_valid pulses to close the job.
// PARAMETERS
//  MUL_W          73728  width of one MUL result beat / MUL_results
//  DRAIN_TIMEOUT  64     cycles in DRAIN with no Psum_valid before the job is aborted
// PORTS
//  clk             in   1      clock, rising edge
//  rst             in   1      synchronous reset, active-high
//  job_start       in   1      1-cycle pulse; samples job_wsize/job_stride/job_nbeats
//  job_wsize       in   4      0=3x3, 1=5x5, 2=7x7; >2 is illegal
//  job_stride      in   1      forwarded to stride
//  job_nbeats      in   8      beats (window positions) in this job
//  job_busy        out  1      high from the cycle after an accepted start until done/err
//  job_done        out  1      1-cycle pulse: all beats issued, all Psums returned
//  job_err         out  1      1-cycle pulse: illegal wsize, surplus Psum, or drain timeout
//  in_valid        in   1      upstream beat valid
//  in_ready        out  1      sequencer can take a beat
//  in_data         in   MUL_W  upstream beat
//  MUL_results     out  MUL_W  to ADDER
//  MUL_DATA_valid  out  1      to ADDER
//  wsize           out  4      to ADDER; held for the whole job
//  wround          out  3      to ADDER
//  stride          out  1      to ADDER; held for the whole job
//  Psum_valid      in   1      from ADDER; one pulse per issued beat
// BEHAVIOUR
//  - All outputs registered.
//  - Reset: every output = 0; state IDLE; beat/psum counters = 0.
//  - rst mid-job aborts silently: no done/err pulse; in-flight Psums are discarded.
//  - NR (rounds per beat) = 1/2/4 for wsize 0/1/2.
//  - FSM: IDLE -> FETCH -> ISSUE -> (FETCH | DRAIN) -> IDLE.
//  - IDLE:
//    - job_start with job_wsize>2: job_err next cycle; stay IDLE.
//    - job_start with job_nbeats=0: job_done next cycle; no issue.
//    - Otherwise latch the job fields; drive wsize/stride; go FETCH.
//    - job_start outside IDLE is ignored.
//  - FETCH:
//    - in_ready=1.
//    - On in_valid&in_ready at edge T: MUL_results<=in_data; MUL_DATA_valid=1, wround=0 from T+1.
//  - ISSUE:
//    - in_ready=0; MUL_DATA_valid=1 for NR back-to-back cycles; wround 0..NR-1.
//    - MUL_results is stable across all rounds.
//    - After the last round: MUL_DATA_valid=0; go FETCH if beats remain, else DRAIN.
//    - This gives a minimum 1-cycle valid gap between beats.
//  - Psum counting:
//    - Psum_valid is counted in FETCH, ISSUE and DRAIN.
//    - A pulse that would exceed job_nbeats: job_err next cycle, then IDLE.
//  - DRAIN:
//    - When psum_cnt == job_nbeats: job_done next cycle, then IDLE.
//    - Timer reloads on every Psum_valid; expiry at DRAIN_TIMEOUT: job_err, then IDLE.
//  - Psum_valid in the same cycle as a state transition is still counted.
//  - In IDLE, Psum_valid is ignored.
//  - job_busy drops in the same cycle job_done/job_err is high.
//  - MUL_results keeps its last value when idle; it is cleared only by rst.
// CONFIGURATION
//  SEQ_STALL_CNT_EN defined:
//    - Adds output stall_cnt [15:0].
//    - Counts FETCH cycles with in_valid=0; saturates at 16'hFFFF.
//    - Clears on an accepted job_start and on rst.
//  SEQ_STALL_CNT_EN undefined: port and logic absent; all other behaviour identical.
// TESTING
//  1. wsize=0, nbeats=1, in_valid held high, Psum_valid 3 cycles later
//     -> one MUL_DATA_valid cycle with wround=0, then job_done.
//  2. wsize=2, nbeats=2, stride=1
//     -> wround 0,1,2,3 / gap / 0,1,2,3; wsize=2, stride=1 held throughout;
//        job_done after the 2nd Psum_valid.
//  3. wsize=1, nbeats=3, in_valid low 5 cycles before beat 2
//     -> in_ready high throughout the stall; no MUL_DATA_valid during it;
//        stall_cnt=5 when SEQ_STALL_CNT_EN is defined.
//  4. job_wsize=3 -> job_err pulse, no in_ready;
//     nbeats=1 with Psum_valid never returned -> job_err 64 cycles after DRAIN entry.
//  5. rst asserted during ISSUE of a 7x7 job
//     -> next cycle all outputs 0, state IDLE;
//        a new 3x3 job then completes normally.
//  6. job_start pulsed while busy -> ignored;
//     extra Psum_valid beyond nbeats -> job_err.

Source files
------------

// File: rtl/mul_round_sequencer_if.sv
// Upstream beat handshake plus the ADDER-tree input bus driven by mul_round_sequencer.
// master = sequencer side, slave = upstream source / ADDER side.
interface mul_round_sequencer_if #(
    parameter int MUL_W = 73728
);
    logic             in_valid;
    logic             in_ready;
    logic [MUL_W-1:0] in_data;
    logic [MUL_W-1:0] MUL_results;
    logic             MUL_DATA_valid;
    logic [3:0]       wsize;
    logic [2:0]       wround;
    logic             stride;
    logic             Psum_valid;

    modport master (
        input  in_valid, in_data, Psum_valid,
        output in_ready, MUL_results, MUL_DATA_valid, wsize, wround, stride
    );

    modport slave (
        output in_valid, in_data, Psum_valid,
        input  in_ready, MUL_results, MUL_DATA_valid, wsize, wround, stride
    );
endinterface

// File: rtl/mul_round_sequencer.sv
// Fetches MUL beats and replays each for 1/2/4 wrounds into the ADDER tree; optional SEQ_STALL_CNT_EN adds stall_cnt.
// Latency: beat accepted at edge T is on MUL_results with wround=0 from T+1; job_done one cycle after the last Psum.
// Backpressure: in_ready only in FETCH; one beat in flight, at least one idle cycle between beats.
module mul_round_sequencer #(
    parameter int MUL_W         = 73728,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        job_start,
    input  logic [3:0]  job_wsize,
    input  logic        job_stride,
    input  logic [7:0]  job_nbeats,
    output logic        job_busy,
    output logic        job_done,
    output logic        job_err,
`ifdef SEQ_STALL_CNT_EN
    output logic [15:0] stall_cnt,
`endif
    mul_round_sequencer_if.master bus
);
    localparam int TW = $clog2(DRAIN_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DRAIN} state_t;

    state_t        state;
    logic [7:0]    nbeats;
    logic [7:0]    beat_cnt;
    logic [7:0]    psum_cnt;
    logic [2:0]    last_round;
    logic [TW-1:0] timer;
    logic [8:0]    psum_nxt;
    logic          psum_over;
    logic          start_acc;

    function automatic logic [2:0] last_round_of(input logic [3:0] ws);
        case (ws)
            4'd1:    return 3'd1;
            4'd2:    return 3'd3;
            default: return 3'd0;
        endcase
    endfunction

    assign psum_nxt  = {1'b0, psum_cnt} + {8'd0, bus.Psum_valid};
    assign psum_over = bus.Psum_valid && (psum_cnt == nbeats);
    assign start_acc = (state == IDLE) && job_start && (job_wsize <= 4'd2) && (job_nbeats != 8'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            nbeats             <= '0;
            beat_cnt           <= '0;
            psum_cnt           <= '0;
            last_round         <= '0;
            timer              <= '0;
            job_busy           <= 1'b0;
            job_done           <= 1'b0;
            job_err            <= 1'b0;
            bus.in_ready       <= 1'b0;
            bus.MUL_results    <= '0;
            bus.MUL_DATA_valid <= 1'b0;
            bus.wsize          <= '0;
            bus.wround         <= '0;
            bus.stride         <= 1'b0;
        end else begin
            job_done <= 1'b0;
            job_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (job_start && job_wsize > 4'd2) begin
                        job_err <= 1'b1;
                    end else if (job_start && job_nbeats == 8'd0) begin
                        job_done <= 1'b1;
                    end else if (start_acc) begin
                        nbeats       <= job_nbeats;
                        last_round   <= last_round_of(job_wsize);
                        beat_cnt     <= '0;
                        psum_cnt     <= '0;
                        bus.wsize    <= job_wsize;
                        bus.stride   <= job_stride;
                        job_busy     <= 1'b1;
                        bus.in_ready <= 1'b1;
                        state        <= FETCH;
                    end
                end
                default: begin
                    // A surplus Psum overrides whatever the active state would do.
                    if (psum_over) begin
                        job_err            <= 1'b1;
                        job_busy           <= 1'b0;
                        bus.in_ready       <= 1'b0;
                        bus.MUL_DATA_valid <= 1'b0;
                        bus.wround         <= '0;
                        state              <= IDLE;
                    end else begin
                        psum_cnt <= psum_nxt[7:0];
                        case (state)
                            FETCH: begin
                                if (bus.in_valid) begin
                                    bus.MUL_results    <= bus.in_data;
                                    bus.MUL_DATA_valid <= 1'b1;
                                    bus.wround         <= '0;
                                    bus.in_ready       <= 1'b0;
                                    state              <= ISSUE;
                                end
                            end
                            ISSUE: begin
                                if (bus.wround == last_round) begin
                                    bus.MUL_DATA_valid <= 1'b0;
                                    bus.wround         <= '0;
                                    beat_cnt           <= beat_cnt + 8'd1;
                                    if ((beat_cnt + 8'd1) < nbeats) begin
                                        bus.in_ready <= 1'b1;
                                        state        <= FETCH;
                                    end else begin
                                        timer <= '0;
                                        state <= DRAIN;
                                    end
                                end else begin
                                    bus.wround <= bus.wround + 3'd1;
                                end
                            end
                            DRAIN: begin
                                if (psum_nxt == {1'b0, nbeats}) begin
                                    job_done <= 1'b1;
                                    job_busy <= 1'b0;
                                    state    <= IDLE;
                                end else if (bus.Psum_valid) begin
                                    timer <= '0;
                                end else if (timer == TW'(DRAIN_TIMEOUT - 1)) begin
                                    job_err  <= 1'b1;
                                    job_busy <= 1'b0;
                                    state    <= IDLE;
                                end else begin
                                    timer <= timer + TW'(1);
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

`ifdef SEQ_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            stall_cnt <= '0;
        end else if (state == FETCH && !bus.in_valid && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mul_round_sequencer.sv
// Self-checking bench for mul_round_sequencer: job table plus hand-written corner sequences,
// with a scoreboard of expected (beat, wround) issues filled on each upstream handshake.
module tb_mul_round_sequencer;
    localparam int W = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       job_start;
    logic [3:0] job_wsize;
    logic       job_stride;
    logic [7:0] job_nbeats;
    logic       job_busy, job_done, job_err;
`ifdef SEQ_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    mul_round_sequencer_if #(.MUL_W(W)) bus();

    mul_round_sequencer #(.MUL_W(W), .DRAIN_TIMEOUT(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .job_start  (job_start),
        .job_wsize  (job_wsize),
        .job_stride (job_stride),
        .job_nbeats (job_nbeats),
        .job_busy   (job_busy),
        .job_done   (job_done),
        .job_err    (job_err),
`ifdef SEQ_STALL_CNT_EN
        .stall_cnt  (stall_cnt),
`endif
        .bus        (bus)
    );

    typedef struct {
        logic [W-1:0] dat;
        logic [2:0]   rnd;
    } exp_t;

    typedef struct {
        logic [3:0] ws;
        logic       st;
        logic [7:0] nb;
        int         lat;
        bit         e_done;
        bit         e_err;
        int         e_vcyc;
        bit         e_busy;
    } vec_t;

    exp_t         exp_q[$];
    logic [W-1:0] src_q[$];
    int           psum_due[$];

    int   checks = 0, failures = 0, cyc = 0;
    logic [3:0] cur_wsize = '0;
    logic cur_stride = 1'b0;
    int   cur_nr = 1;
    bit   psum_en = 1'b0;
    int   psum_lat = 1, psum_force = 0;
    int   stall_at = -1, stall_len = 0, acc_cnt = 0;
    bit   done_seen, err_seen, rdy_seen;
    int   done_cyc, err_cyc, last_v_cyc, vcyc, last_psum_cyc, psum_sent;
    int   budget;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Drive inputs for one cycle, cross the rising edge, then sample at the falling edge.
    task automatic tick();
        logic [W-1:0] d;
        exp_t         e;
        bit           hs;
        if (acc_cnt == stall_at && stall_len > 0) begin
            bus.in_valid = 1'b0;
            if (bus.in_ready === 1'b1) stall_len--;
        end else begin
            bus.in_valid = (src_q.size() > 0);
        end
        bus.in_data = (src_q.size() > 0) ? src_q[0] : '0;
        if (psum_force > 0) begin
            bus.Psum_valid = 1'b1;
            psum_force--;
        end else if (psum_due.size() > 0 && psum_due[0] <= cyc) begin
            bus.Psum_valid = 1'b1;
            void'(psum_due.pop_front());
        end else begin
            bus.Psum_valid = 1'b0;
        end
        if (bus.Psum_valid) begin
            psum_sent++;
            last_psum_cyc = cyc;
        end
        hs = bus.in_valid && (bus.in_ready === 1'b1) && !rst;
        @(negedge clk);
        if (hs) begin
            d = src_q.pop_front();
            acc_cnt++;
            for (int k = 0; k < cur_nr; k++) exp_q.push_back('{d, 3'(k)});
        end
        if (bus.in_ready === 1'b1) rdy_seen = 1'b1;
        if (bus.MUL_DATA_valid === 1'b1) begin
            vcyc++;
            last_v_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL valid_without_beat cyc=%0d wround=%0d", cyc, bus.wround);
            end else begin
                e = exp_q.pop_front();
                check("mul_results", bus.MUL_results, e.dat);
                check("wround", bus.wround, e.rnd);
                check("wsize_held", bus.wsize, cur_wsize);
                check("stride_held", bus.stride, cur_stride);
                check("in_ready_during_issue", bus.in_ready, 0);
                if (psum_en && int'(e.rnd) == cur_nr - 1) psum_due.push_back(cyc + psum_lat);
            end
        end
        if (job_done === 1'b1) begin done_seen = 1'b1; done_cyc = cyc; end
        if (job_err === 1'b1) begin err_seen = 1'b1; err_cyc = cyc; end
        cyc++;
    endtask

    task automatic load_beats(input int n);
        for (int i = 0; i < n; i++) src_q.push_back(W'($urandom));
    endtask

    task automatic start_job(input logic [3:0] ws, input logic st, input logic [7:0] nb);
        done_seen = 0; err_seen = 0; rdy_seen = 0;
        vcyc = 0; acc_cnt = 0; psum_sent = 0; last_psum_cyc = -1;
        if (ws <= 4'd2 && nb != 0) begin
            cur_wsize  = ws;
            cur_stride = st;
            cur_nr     = (ws == 4'd0) ? 1 : (ws == 4'd1) ? 2 : 4;
        end
        job_start = 1'b1; job_wsize = ws; job_stride = st; job_nbeats = nb;
        tick();
        job_start = 1'b0;
    endtask

    task automatic wait_end(input int limit);
        budget = limit;
        while (!done_seen && !err_seen && budget > 0) begin
            tick();
            budget--;
        end
        if (!done_seen && !err_seen) begin
            checks++;
            failures++;
            $display("FAIL job_end_timeout done=%0d err=%0d required=done_or_err", done_seen, err_seen);
        end
    endtask

    task automatic clear_models();
        exp_q.delete();
        src_q.delete();
        psum_due.delete();
        psum_force = 0;
    endtask

    function automatic logic [63:0] out_vec();
        return {19'd0, job_busy, job_done, job_err, bus.in_ready, bus.MUL_DATA_valid,
                bus.wsize, bus.wround, bus.stride, bus.MUL_results};
    endfunction

    initial begin
        vec_t tbl[7];
        tbl[0] = '{4'd0,  1'b0, 8'd1, 3, 1'b1, 1'b0, 1,  1'b1};
        tbl[1] = '{4'd2,  1'b1, 8'd2, 1, 1'b1, 1'b0, 8,  1'b1};
        tbl[2] = '{4'd1,  1'b0, 8'd3, 2, 1'b1, 1'b0, 6,  1'b1};
        tbl[3] = '{4'd3,  1'b0, 8'd1, 3, 1'b0, 1'b1, 0,  1'b0};
        tbl[4] = '{4'd15, 1'b1, 8'd4, 3, 1'b0, 1'b1, 0,  1'b0};
        tbl[5] = '{4'd0,  1'b0, 8'd0, 3, 1'b1, 1'b0, 0,  1'b0};
        tbl[6] = '{4'd1,  1'b1, 8'd5, 4, 1'b1, 1'b0, 10, 1'b1};

        rst = 1'b1; job_start = 1'b0; job_wsize = '0; job_stride = 1'b0; job_nbeats = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.Psum_valid = 1'b0;
        tick(); tick();
        check("reset_outputs", out_vec(), 64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            psum_en  = 1'b1;
            psum_lat = tbl[i].lat;
            if (tbl[i].e_vcyc > 0) load_beats(int'(tbl[i].nb));
            start_job(tbl[i].ws, tbl[i].st, tbl[i].nb);
            check($sformatf("busy_after_start[%0d]", i), job_busy, tbl[i].e_busy);
            wait_end(400);
            check($sformatf("done[%0d]", i), done_seen, tbl[i].e_done);
            check($sformatf("err[%0d]", i), err_seen, tbl[i].e_err);
            check($sformatf("valid_cycles[%0d]", i), vcyc, tbl[i].e_vcyc);
            check($sformatf("in_ready_seen[%0d]", i), rdy_seen, tbl[i].e_busy);
            check($sformatf("busy_at_end[%0d]", i), job_busy, 0);
            check($sformatf("issues_left[%0d]", i), exp_q.size(), 0);
            if (tbl[i].e_vcyc > 0) begin
                check($sformatf("psums_before_done[%0d]", i), psum_sent, tbl[i].nb);
                check($sformatf("done_after_last_psum[%0d]", i), done_cyc >= last_psum_cyc, 1);
            end
            tick(); tick();
            clear_models();
        end

        // Upstream stall of 5 FETCH cycles before beat 2.
        psum_en = 1'b1; psum_lat = 2;
        load_beats(3);
        stall_at = 1; stall_len = 5;
        start_job(4'd1, 1'b0, 8'd3);
        budget = 100;
        while (stall_len > 0 && budget > 0) begin
            tick();
            budget--;
            if (stall_len > 0 && stall_len < 5) check("in_ready_in_stall", bus.in_ready, 1);
        end
        check("stall_consumed", stall_len, 0);
        stall_at = -1;
        wait_end(400);
        check("stall_done", done_seen, 1);
        check("stall_valid_cycles", vcyc, 6);
`ifdef SEQ_STALL_CNT_EN
        check("stall_cnt", stall_cnt, 5);
`endif
        tick(); tick();
        clear_models();

        // Psums never return: drain timeout.
        psum_en = 1'b0;
        load_beats(1);
        start_job(4'd0, 1'b0, 8'd1);
        wait_end(200);
        check("timeout_err", err_seen, 1);
        check("timeout_no_done", done_seen, 0);
        check("timeout_cycles", err_cyc - last_v_cyc, 65);
        check("timeout_busy", job_busy, 0);
        tick(); tick();
        clear_models();

        // Reset during ISSUE of a 7x7 job, then a fresh 3x3 job.
        psum_en = 1'b1; psum_lat = 2;
        load_beats(2);
        start_job(4'd2, 1'b1, 8'd2);
        budget = 50;
        while (!(bus.MUL_DATA_valid === 1'b1 && bus.wround == 3'd1) && budget > 0) begin
            tick();
            budget--;
        end
        check("reached_issue", bus.wround, 1);
        rst = 1'b1;
        tick();
        check("midjob_reset_outputs", out_vec(), 64'd0);
        rst = 1'b0;
        clear_models();
        tick(); tick(); tick();
        check("midjob_reset_silent", done_seen | err_seen, 0);
        load_beats(1);
        start_job(4'd0, 1'b0, 8'd1);
        wait_end(100);
        check("post_reset_done", done_seen, 1);
        check("post_reset_valid_cycles", vcyc, 1);
        tick(); tick();
        clear_models();

        // job_start while busy is ignored.
        psum_en = 1'b1; psum_lat = 2;
        load_beats(2);
        start_job(4'd1, 1'b0, 8'd2);
        tick();
        job_start = 1'b1; job_wsize = 4'd0; job_nbeats = 8'd5;
        tick();
        job_start = 1'b0;
        wait_end(200);
        check("busy_start_done", done_seen, 1);
        check("busy_start_valid_cycles", vcyc, 4);
        check("busy_start_wsize", bus.wsize, 1);
        tick(); tick();
        clear_models();

        // Surplus Psum during ISSUE.
        psum_en = 1'b0;
        load_beats(1);
        start_job(4'd2, 1'b0, 8'd1);
        budget = 20;
        while (bus.MUL_DATA_valid !== 1'b1 && budget > 0) begin
            tick();
            budget--;
        end
        psum_force = 2;
        wait_end(50);
        check("surplus_err", err_seen, 1);
        check("surplus_no_done", done_seen, 0);
        check("surplus_err_timing", err_cyc, last_psum_cyc);
        check("surplus_busy", job_busy, 0);
        clear_models();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
